// File: rtl/gat_stage_scheduler.sv
// Stage sequencer for the GAT pipeline: launches SPMM, DMVM, softmax and aggregation
// in order for every layer, and keeps per-stage latency, run totals, progress bits and a watchdog.
module gat_stage_scheduler #(
  parameter int NUM_LAYERS     = 2,
  parameter int LAYER_W        = 4,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  spmm_rdy_i,
  input  logic                  dmvm_rdy_i,
  input  logic                  sm_rdy_i,
  input  logic                  aggr_rdy_i,
  output logic                  spmm_vld_o,
  output logic                  dmvm_vld_o,
  output logic                  sm_vld_o,
  output logic                  aggr_vld_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LAYER_W-1:0]    layer_o,
  output logic [1:0]            stage_o,
  output logic [7:0]            status_o,
  output logic [3:0][CNT_W-1:0] stage_cycles_o,
  output logic [CNT_W-1:0]      total_cycles_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // ISSUE | one-cycle launch pulse for stage_o
  // WAIT  | waiting for the current stage's rdy, watchdog running
  // DONE  | one-cycle done pulse, total latched
  // ERR   | watchdog expired, position frozen until start_i or abort_i
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] run_total;
  logic [3:0]       rdy_vec;
  logic             cur_rdy;
  logic             last_layer;
  logic             timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign rdy_vec     = {aggr_rdy_i, sm_rdy_i, dmvm_rdy_i, spmm_rdy_i};
  assign cur_rdy     = rdy_vec[stage_o];
  assign last_layer  = (layer_o >= LAST_LAYER);
  assign timeout_hit = (wait_cnt >= TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_i) state_nxt = S_ISSUE;
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT: begin
          // rdy outranks the watchdog when both land on the same cycle
          if (cur_rdy) begin
            if (stage_o == 2'd3 && last_layer) state_nxt = S_DONE;
            else                               state_nxt = S_ISSUE;
          end else if (timeout_hit) begin
            state_nxt = S_ERR;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        S_ERR:   if (start_i) state_nxt = S_ISSUE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy_o     = (state == S_ISSUE) || (state == S_WAIT);
  assign done_o     = (state == S_DONE);
  assign err_o      = (state == S_ERR);
  assign spmm_vld_o = (state == S_ISSUE) && (stage_o == 2'd0);
  assign dmvm_vld_o = (state == S_ISSUE) && (stage_o == 2'd1);
  assign sm_vld_o   = (state == S_ISSUE) && (stage_o == 2'd2);
  assign aggr_vld_o = (state == S_ISSUE) && (stage_o == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_o        <= '0;
      stage_o        <= '0;
      status_o       <= '0;
      wait_cnt       <= '0;
      run_total      <= '0;
      stage_cycles_o <= '0;
      total_cycles_o <= '0;
    end else if (!abort_i) begin
      case (state)
        S_IDLE, S_ERR: begin
          if (start_i) begin
            status_o  <= '0;
            layer_o   <= '0;
            stage_o   <= '0;
            run_total <= '0;
          end
        end
        S_ISSUE: begin
          status_o[{1'b0, stage_o}] <= 1'b1;
          wait_cnt                  <= '0;
          run_total                 <= sat_inc(run_total);
        end
        S_WAIT: begin
          run_total <= sat_inc(run_total);
          if (cur_rdy) begin
            stage_cycles_o[stage_o]   <= sat_inc(wait_cnt);
            status_o[{1'b1, stage_o}] <= 1'b1;
            if (stage_o != 2'd3) begin
              stage_o <= stage_o + 2'd1;
            end else if (!last_layer) begin
              layer_o <= layer_o + LAYER_W'(1);
              stage_o <= 2'd0;
            end
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end
        S_DONE: total_cycles_o <= run_total;
        default: ;
      endcase
    end
  end

endmodule
